push_button: RTL and testbench

Push-button conditioner. It turns a raw, bouncing, asynchronous button level `x` into a single-clock-cycle pulse `z` for each debounced press.

---
 rtl/pb_tick_gen.sv | 31 +++
 rtl/push_button.sv | 72 +++++++
 tb/tb_push_button.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pb_tick_gen.sv
// Sample-enable divider for the push-button conditioner.
// Ports: clk, rst (async, active-high), tick (one-cycle enable every DIV clks).
module pb_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With DIV=1 the counter is pinned at 0 == LAST, so tick is always 1.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/push_button.sv
// Push-button conditioner: sync -> divided sampling -> debounce -> press pulse.
// Ports: clk, rst (async, active-high), x (raw async level), z (one-clk pulse).
module push_button #(
    parameter int DIV    = 1,
    parameter int DB_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    logic              tick;
    logic              s1_q;
    logic              s2_q;
    logic [DB_LEN-1:0] sh_q;
    logic [DB_LEN-1:0] sh_d;
    logic              lvl_q;
    logic              lvl_d;
    logic              z_q;
    logic              z_d;
    logic [DB_LEN-1:0] nxt;
    logic              all_one;
    logic              all_zero;

    pb_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        nxt      = {sh_q[DB_LEN-2:0], s2_q};
        all_one  = &nxt;
        all_zero = ~|nxt;
        sh_d     = sh_q;
        lvl_d    = lvl_q;
        z_d      = 1'b0;
        if (tick) begin
            sh_d = nxt;
            // Mixed windows keep the old level: this is the hysteresis
            // that stops release bounce from re-arming the pulse.
            if (all_one) begin
                lvl_d = 1'b1;
            end else if (all_zero) begin
                lvl_d = 1'b0;
            end
            z_d = ~lvl_q & all_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            sh_q  <= '0;
            lvl_q <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            s1_q  <= x;
            s2_q  <= s1_q;
            sh_q  <= sh_d;
            lvl_q <= lvl_d;
            z_q   <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: tb/tb_push_button.sv
// Directed bench for push_button (DIV=1 and DIV=4 instances).
// Inputs change away from clk rising edges; outputs read 1 ns after them.
module tb_push_button;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x   = 1'b0;
    logic x4  = 1'b0;
    logic z;
    logic z4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    push_button #(.DIV(1), .DB_LEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z)
    );

    push_button #(.DIV(4), .DB_LEN(3)) dut4 (
        .clk (clk),
        .rst (rst),
        .x   (x4),
        .z   (z4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int pulses;
        int first;
        rst = 1'b1;
        x   = 1'b1;
        x4  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (z !== 1'b0 || z4 !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: z=%b z4=%b required 0 0", z, z4);
            end
        end
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        first  = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (z === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL reset_release_pulses: got %0d required 1", pulses);
        end
        n_cmp++;
        if (first !== 4) begin
            n_bad++;
            $display("FAIL reset_release_latency: edge %0d required 4", first);
        end
        x = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_glitch_reject();
        int pulses;
        pulses = 0;
        for (int r = 0; r < 3; r++) begin
            x = 1'b1;
            for (int i = 0; i < 2; i++) begin
                step();
                if (z === 1'b1) pulses++;
            end
            x = 1'b0;
            for (int i = 0; i < 2; i++) begin
                step();
                if (z === 1'b1) pulses++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (z === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL glitch_reject: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_clean_press();
        int pulses;
        int first;
        pulses = 0;
        first  = -1;
        x      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 2) x = 1'b0;
            if (z === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL clean_press_pulses: got %0d required 1", pulses);
        end
        n_cmp++;
        if (first !== 4) begin
            n_bad++;
            $display("FAIL clean_press_latency: edge %0d required 4", first);
        end
    endtask

    task automatic test_long_hold();
        int pulses;
        pulses = 0;
        x      = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (z === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL long_hold_pulses: got %0d required 1", pulses);
        end
        n_cmp++;
        if (dut.lvl_q !== 1'b1) begin
            n_bad++;
            $display("FAIL long_hold_level: lvl=%b required 1", dut.lvl_q);
        end
    endtask

    task automatic test_release_bounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            x = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
            if (z === 1'b1) pulses++;
        end
        x = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (z === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL release_bounce: got %0d pulses required 0", pulses);
        end
        n_cmp++;
        if (dut.lvl_q !== 1'b0) begin
            n_bad++;
            $display("FAIL release_level: lvl=%b required 0", dut.lvl_q);
        end
        pulses = 0;
        x      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 2) x = 1'b0;
            if (z === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL press_after_bounce: got %0d required 1", pulses);
        end
    endtask

    task automatic test_reset_mid_press();
        int pulses;
        int first;
        bit seen;
        seen = 1'b0;
        x    = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (z === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL mid_press_setup: z=%b required 1 within 10", z);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (z !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_press_async_clear: z=%b required 0", z);
        end
        step();
        step();
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        first  = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (z === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (pulses !== 1 || first !== 4) begin
            n_bad++;
            $display("FAIL mid_press_repress: %0d pulses at %0d required 1 at 4",
                     pulses, first);
        end
        x = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_div4();
        int pulses;
        int first;
        rst = 1'b1;
        x   = 1'b0;
        x4  = 1'b0;
        step();
        @(negedge clk);
        rst    = 1'b0;
        x4     = 1'b1;
        pulses = 0;
        first  = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i == 11) x4 = 1'b0;
            if (z4 === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL div4_press_pulses: got %0d required 1", pulses);
        end
        n_cmp++;
        if (first !== 11) begin
            n_bad++;
            $display("FAIL div4_tick_align: edge %0d required 11", first);
        end
        pulses = 0;
        x4     = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i == 7) x4 = 1'b0;
            if (z4 === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL div4_short_press: got %0d pulses required 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_glitch_reject();
        test_clean_press();
        test_long_hold();
        test_release_bounce();
        test_reset_mid_press();
        test_div4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
